// File: rtl/clock_core.sv
// clock_core: 100 MHz -> 1 s timebase, 24-hour packed-BCD HH:MM:SS,
// two-button set mode (mode / increment) and a free-running 2 Hz blink flag.

// Per-button path: 2-flop synchronizer, stability debounce, rising-edge press pulse.
module clock_core_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0;
  logic             sync1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles; pulse on 0->1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync1 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync1;
          cnt   <= '0;
          press <= sync1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

module clock_core #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] set_state,
  output logic       sec_tick,
  output logic       blink
);

  localparam int PRE_W = $clog2(CLK_HZ);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] PRE_PENULT = PRE_W'(CLK_HZ - 2);

  localparam int BLK_Q = CLK_HZ / 4;
  localparam int BLK_W = (BLK_Q > 1) ? $clog2(BLK_Q) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLK_Q - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hour_q, hour_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       sec_q, sec_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_q;
  logic             mode_p;
  logic             inc_p;

  // BCD +1 modulo 60 (seconds / minutes).
  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    logic [7:0] r;
    if (v[7:4] >= 4'd5 && v[3:0] >= 4'd9) r = 8'h00;
    else if (v[3:0] >= 4'd9)              r = {v[7:4] + 4'd1, 4'd0};
    else                                  r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // BCD +1 modulo 24 (hours).
  function automatic logic [7:0] inc_mod24(input logic [7:0] v);
    logic [7:0] r;
    if (v[7:4] >= 4'd2 && v[3:0] >= 4'd3) r = 8'h00;
    else if (v[3:0] >= 4'd9)              r = {v[7:4] + 4'd1, 4'd0};
    else                                  r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  clock_core_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk   (clk_100MHz),
    .rst   (rst),
    .btn   (btn_mode),
    .press (mode_p)
  );

  clock_core_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk   (clk_100MHz),
    .rst   (rst),
    .btn   (btn_inc),
    .press (inc_p)
  );

  // Next-state, time advance, set-mode edits and prescaler control.
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;

    if (tick_q) begin
      sec_d = inc_mod60(sec_q);
      if (sec_q == 8'h59) begin
        min_d = inc_mod60(min_q);
        if (min_q == 8'h59) hour_d = inc_mod24(hour_q);
      end
    end

    case (state_q)
      RUN: begin
        if (mode_p) begin
          state_d = SET_HOUR;
          pre_d   = '0;
        end else begin
          pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
          // Registered tick is raised one cycle early so it is high exactly
          // while the prescaler sits at its last count in RUN.
          tick_d = (pre_q == PRE_PENULT);
        end
      end
      SET_HOUR: begin
        pre_d = '0;
        if (mode_p)     state_d = SET_MIN;
        else if (inc_p) hour_d  = inc_mod24(hour_q);
      end
      SET_MIN: begin
        pre_d = '0;
        if (mode_p) begin
          state_d = RUN;
          sec_d   = 8'h00;
        end else if (inc_p) begin
          min_d = inc_mod60(min_q);
        end
      end
      default: begin
        state_d = RUN;
        pre_d   = '0;
      end
    endcase
  end

  // State, time and prescaler registers.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      hour_q  <= 8'h00;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      pre_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
    end
  end

  // Free-running blink: toggle every CLK_HZ/4 cycles regardless of mode.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

  assign hour_bcd  = hour_q;
  assign min_bcd   = min_q;
  assign sec_bcd   = sec_q;
  assign set_state = state_q;
  assign sec_tick  = tick_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_clock_core.sv
// tb_clock_core: directed scenarios plus randomized button traffic, checked
// cycle by cycle against a seconds-of-day reference model.
module tb_clock_core;

  localparam int CLK_HZ = 20;
  localparam int DEB    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] set_state;
  logic       sec_tick;
  logic       blink;

  clock_core #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .hour_bcd   (hour_bcd),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .set_state  (set_state),
    .sec_tick   (sec_tick),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: time as seconds of day, mode 0/1/2, prescaler phase,
  // edges since reset release, and scheduled press effects by edge index.
  int secs, st, phase, cyc, ticks_seen, chg_edge;
  logic [1:0] prev_state;
  int mode_q[$];
  int inc_q[$];

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic model_reset();
    secs = 0; st = 0; phase = 0; cyc = 0; ticks_seen = 0;
    prev_state = 2'd0; chg_edge = -1;
    mode_q.delete();
    inc_q.delete();
  endtask

  // Assert reset away from the edge, check the asynchronous clear, hold across one edge.
  task automatic do_reset();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_hour",  hour_bcd,  0);
    check("rst_min",   min_bcd,   0);
    check("rst_sec",   sec_bcd,   0);
    check("rst_state", set_state, 0);
    check("rst_tick",  sec_tick,  0);
    check("rst_blink", blink,     0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock edge: advance the model, then compare every output.
  task automatic step();
    bit m, i, tick;
    int idx, h, mi, s;
    idx = cyc;
    m = 1'b0;
    i = 1'b0;
    if (mode_q.size() > 0 && mode_q[0] == idx) begin m = 1'b1; void'(mode_q.pop_front()); end
    if (inc_q.size() > 0 && inc_q[0] == idx) begin i = 1'b1; void'(inc_q.pop_front()); end
    @(posedge clk);
    tick = (st == 0 && phase == CLK_HZ - 1);
    if (tick) secs = (secs + 1) % 86400;
    h  = secs / 3600;
    mi = (secs / 60) % 60;
    s  = secs % 60;
    case (st)
      0: if (m) begin st = 1; phase = 0; end
         else phase = (phase + 1) % CLK_HZ;
      1: if (m) st = 2;
         else if (i) secs = ((h + 1) % 24) * 3600 + mi * 60 + s;
      default: if (m) begin st = 0; secs = secs - s; phase = 0; end
               else if (i) secs = h * 3600 + ((mi + 1) % 60) * 60 + s;
    endcase
    cyc++;
    #1;
    check("hour",  hour_bcd,  to_bcd(secs / 3600));
    check("min",   min_bcd,   to_bcd((secs / 60) % 60));
    check("sec",   sec_bcd,   to_bcd(secs % 60));
    check("state", set_state, st);
    check("tick",  sec_tick,  (st == 0 && phase == CLK_HZ - 1) ? 1 : 0);
    check("blink", blink,     (cyc / (CLK_HZ / 4)) % 2);
    if (sec_tick === 1'b1) ticks_seen++;
    if (set_state !== prev_state) chg_edge = idx;
    prev_state = set_state;
  endtask

  // Drive buttons for 'hold' cycles, then idle long enough for the debouncer to settle.
  // Returns the edge index at which the press takes effect, or -1 for a glitch.
  task automatic press(input bit m, input bit i, input int hold, output int ev);
    ev = -1;
    btn_mode = m;
    btn_inc  = i;
    if (hold >= DEB) begin
      ev = cyc + DEB + 2;
      if (m) mode_q.push_back(ev);
      if (i) inc_q.push_back(ev);
    end
    repeat (hold) step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (10) step();
  endtask

  task automatic presses(input bit m, input bit i, input int n);
    int ev;
    for (int k = 0; k < n; k++) press(m, i, 10, ev);
  endtask

  task automatic run_until(input int target, input int budget);
    for (int k = 0; k < budget && secs != target; k++) step();
    check("reach_time", secs, target);
  endtask

  initial begin
    int ev, e0, t0, tgt;

    // Power-up reset.
    #1;
    do_reset();
    repeat (25) step();
    check("first_tick_count", ticks_seen, 1);

    // Mode press latency and hour wrap via 25 increments.
    e0 = cyc;
    press(1'b1, 1'b0, 10, ev);
    check("mode_latency", chg_edge - e0, DEB + 2);
    check("in_set_hour", set_state, 1);
    t0 = ticks_seen;
    presses(1'b0, 1'b1, 25);
    check("hour_wrap", hour_bcd, 8'h01);
    repeat (30) step();
    check("no_tick_in_set", ticks_seen - t0, 0);

    // Short glitch is ignored; simultaneous mode+inc takes mode only.
    press(1'b1, 1'b0, DEB - 1, ev);
    check("glitch_state", set_state, 1);
    press(1'b1, 1'b1, 8, ev);
    check("both_state", set_state, 2);
    check("both_hour", hour_bcd, 8'h01);

    // Minute wrap without carry, then resume RUN with seconds cleared.
    presses(1'b0, 1'b1, 59);
    check("min_59", min_bcd, 8'h59);
    presses(1'b0, 1'b1, 1);
    check("min_wrap", min_bcd, 8'h00);
    check("min_wrap_hour", hour_bcd, 8'h01);
    press(1'b1, 1'b0, 10, ev);
    check("resume_state", set_state, 0);
    check("resume_sec", sec_bcd, 8'h00);
    for (int k = 0; k < 60 && sec_tick !== 1'b1; k++) step();
    check("first_tick_after_set", cyc - ev, CLK_HZ);

    // Set 23:59:00, run to 23:59:58, then across midnight.
    presses(1'b1, 1'b0, 1);
    presses(1'b0, 1'b1, 22);
    presses(1'b1, 1'b0, 1);
    presses(1'b0, 1'b1, 59);
    presses(1'b1, 1'b0, 1);
    run_until(86398, 1400);
    check("pre_hour", hour_bcd, 8'h23);
    check("pre_min",  min_bcd,  8'h59);
    check("pre_sec",  sec_bcd,  8'h58);
    repeat (CLK_HZ) step();
    check("last_sec", sec_bcd, 8'h59);
    repeat (CLK_HZ) step();
    check("midnight_hour", hour_bcd, 8'h00);
    check("midnight_min",  min_bcd,  8'h00);
    check("midnight_sec",  sec_bcd,  8'h00);

    // Long run: tick count must match the elapsed seconds exactly.
    t0 = ticks_seen;
    repeat (1500 * CLK_HZ) step();
    check("long_ticks", ticks_seen - t0, 1500);
    check("long_min", min_bcd, 8'h25);

    // Randomized button traffic and idle stretches.
    for (int n = 0; n < 40; n++) begin
      int b;
      case ($urandom_range(0, 4))
        0: press(1'b1, 1'b0, int'($urandom_range(DEB, 12)), ev);
        1: press(1'b0, 1'b1, int'($urandom_range(DEB, 12)), ev);
        2: press(1'b1, 1'b1, int'($urandom_range(DEB, 12)), ev);
        3: begin
          b = int'($urandom_range(0, 1));
          press(b == 0, b == 1, int'($urandom_range(1, DEB - 1)), ev);
        end
        default: repeat (int'($urandom_range(1, 80))) step();
      endcase
    end

    // Mid-operation reset at 12:34:56 in SET_MIN, then blink phase from release.
    do_reset();
    presses(1'b1, 1'b0, 1);
    presses(1'b0, 1'b1, 12);
    presses(1'b1, 1'b0, 1);
    presses(1'b0, 1'b1, 34);
    presses(1'b1, 1'b0, 1);
    tgt = 12 * 3600 + 34 * 60 + 56;
    run_until(tgt, 1400);
    presses(1'b1, 1'b0, 2);
    check("pre_rst_state", set_state, 2);
    check("pre_rst_hour",  hour_bcd,  8'h12);
    check("pre_rst_min",   min_bcd,   8'h34);
    check("pre_rst_sec",   sec_bcd,   8'h56);
    do_reset();
    repeat (4) step();
    check("blink_4", blink, 0);
    step();
    check("blink_5", blink, 1);
    repeat (5) step();
    check("blink_10", blink, 0);
    repeat (15) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
